// File: rtl/elastic_rr_merge.sv
// N-to-1 round-robin merge for valid/ready channels with a single registered output slot.
// Each output word carries the index of the input it came from.
`timescale 1ns/1ps
module elastic_rr_merge #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_INPUTS   = 4,
  localparam int unsigned ID_WIDTH  = $clog2(N_INPUTS)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           en_i,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] din_i,
  input  logic [N_INPUTS-1:0]            din_v_i,
  output logic [N_INPUTS-1:0]            din_r_o,
  output logic [DATA_WIDTH-1:0]          dout_o,
  output logic [ID_WIDTH-1:0]            dout_id_o,
  output logic                           dout_v_o,
  input  logic                           dout_r_i
);

  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  valid_q;
  logic [ID_WIDTH-1:0]   ptr_q;

  logic [N_INPUTS-1:0]   grant;
  logic                  found;
  logic [ID_WIDTH-1:0]   grant_idx;
  logic [ID_WIDTH-1:0]   ptr_nxt;
  logic                  load;
  int unsigned           scan_idx;

  // Reset is folded in so nothing is handshaken on an edge that discards the word.
  assign load      = en_i & ~rst_i & (~valid_q | dout_r_i);
  assign din_r_o   = grant & {N_INPUTS{load}};
  assign dout_v_o  = valid_q & en_i;
  assign dout_o    = data_q;
  assign dout_id_o = id_q;

  // Scan from ptr_q upwards with explicit wrap at N_INPUTS (not at 2**ID_WIDTH).
  always_comb begin
    grant     = '0;
    found     = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < N_INPUTS; i++) begin
      scan_idx = 32'(ptr_q) + i;
      if (scan_idx >= N_INPUTS) scan_idx = scan_idx - N_INPUTS;
      if (!found && din_v_i[scan_idx]) begin
        found           = 1'b1;
        grant_idx       = ID_WIDTH'(scan_idx);
        grant[scan_idx] = 1'b1;
      end
    end
  end

  assign ptr_nxt = (grant_idx == ID_WIDTH'(N_INPUTS - 1)) ? '0 : grant_idx + ID_WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
    end else if (load) begin
      if (found) begin
        data_q  <= din_i[32'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        id_q    <= grant_idx;
        valid_q <= 1'b1;
        ptr_q   <= ptr_nxt;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_elastic_rr_merge.sv
// Directed table, hand sequences and a scoreboarded random run for elastic_rr_merge
// (N=4 instance for most tests, N=3 instance for the skip/wrap case).
`timescale 1ns/1ps
module tb_elastic_rr_merge;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // N=4 instance
  logic         rst, en, rdy, dv;
  logic [127:0] din;
  logic [3:0]   v, dr;
  logic [31:0]  dd;
  logic [1:0]   did;

  elastic_rr_merge #(.DATA_WIDTH(32), .N_INPUTS(4)) dut_a (
    .clk_i(clk), .rst_i(rst), .en_i(en), .din_i(din), .din_v_i(v), .din_r_o(dr),
    .dout_o(dd), .dout_id_o(did), .dout_v_o(dv), .dout_r_i(rdy)
  );

  // N=3 instance
  logic        b_rst, b_en, b_rdy, b_dv;
  logic [95:0] b_din;
  logic [2:0]  b_v, b_dr;
  logic [31:0] b_dd;
  logic [1:0]  b_did;

  elastic_rr_merge #(.DATA_WIDTH(32), .N_INPUTS(3)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .en_i(b_en), .din_i(b_din), .din_v_i(b_v), .din_r_o(b_dr),
    .dout_o(b_dd), .dout_id_o(b_did), .dout_v_o(b_dv), .dout_r_i(b_rdy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic [3:0] er, input logic ev,
                       input logic [1:0] eid, input logic [31:0] ed);
    chk({tag, ".din_r"}, 64'(dr), 64'(er));
    chk({tag, ".dout_v"}, 64'(dv), 64'(ev));
    chk({tag, ".dout_id"}, 64'(did), 64'(eid));
    chk({tag, ".dout"}, 64'(dd), 64'(ed));
  endtask

  task automatic chk_b(input string tag, input logic [2:0] er, input logic ev,
                       input logic [1:0] eid, input logic [31:0] ed);
    chk({tag, ".din_r"}, 64'(b_dr), 64'(er));
    chk({tag, ".dout_v"}, 64'(b_dv), 64'(ev));
    chk({tag, ".dout_id"}, 64'(b_did), 64'(eid));
    chk({tag, ".dout"}, 64'(b_dd), 64'(ed));
  endtask

  // Drive at edge+1, check at edge+3, then advance to the next edge+1.
  task automatic cyc_a(input string tag, input logic ien, input logic [3:0] iv, input logic irdy,
                       input logic [3:0] er, input logic ev, input logic [1:0] eid,
                       input logic [31:0] ed);
    en = ien; v = iv; rdy = irdy;
    #2;
    chk_a(tag, er, ev, eid, ed);
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input string tag, input logic [2:0] iv,
                       input logic [2:0] er, input logic ev, input logic [1:0] eid,
                       input logic [31:0] ed);
    b_v = iv;
    #2;
    chk_b(tag, er, ev, eid, ed);
    @(posedge clk); #1;
  endtask

  task automatic reset_a();
    rst = 1'b1; v = '0; en = 1'b1; rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [3:0]  v;
    logic        rdy;
    logic        chk;
    logic [3:0]  exp_r;
    logic        exp_v;
    logic [1:0]  exp_id;
    logic [31:0] exp_d;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic e, input logic [3:0] iv, input logic rd,
                              input logic c, input logic [3:0] er, input logic ev,
                              input logic [1:0] eid, input logic [31:0] ed);
    vec_t t;
    t.rst = r; t.en = e; t.v = iv; t.rdy = rd; t.chk = c;
    t.exp_r = er; t.exp_v = ev; t.exp_id = eid; t.exp_d = ed;
    return t;
  endfunction

  localparam logic [31:0] D0 = 32'hC0DE_0000;
  localparam logic [31:0] D1 = 32'hC0DE_0001;
  localparam logic [31:0] D2 = 32'hC0DE_0002;
  localparam logic [31:0] D3 = 32'hC0DE_0003;

  vec_t tbl [23];

  // Random-phase scoreboard
  logic [33:0] sb_q [$];
  logic [3:0]  pend;
  int          wait_cnt [4];
  int unsigned seq_no;

  task automatic rand_cycle(input bit gen);
    logic [33:0] exp_w;
    for (int k = 0; k < 4; k++) begin
      if (gen && !pend[k] && $urandom_range(0, 99) < 60) begin
        pend[k] = 1'b1;
        din[k*32 +: 32] = {6'(k), 26'(seq_no)};
        seq_no++;
      end
    end
    v   = pend;
    rdy = gen ? ($urandom_range(0, 99) < 70) : 1'b1;
    en  = gen ? ($urandom_range(0, 99) < 90) : 1'b1;
    #2;
    chk("rand.onehot", 64'($countones(dr) <= 1), 64'd1);
    chk("rand.r_only_valid", 64'(dr & ~v), 64'd0);
    if (!en) begin
      chk("rand.frz_v", 64'(dv), 64'd0);
      chk("rand.frz_r", 64'(dr), 64'd0);
    end
    if (dv && rdy) begin
      if (sb_q.size() == 0) begin
        chk("rand.unexpected_word", 64'(dd), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_w = sb_q.pop_front();
        chk("rand.id", 64'(did), 64'(exp_w[33:32]));
        chk("rand.data", 64'(dd), 64'(exp_w[31:0]));
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (dr[k]) begin
        sb_q.push_back({2'(k), din[k*32 +: 32]});
        for (int j = 0; j < 4; j++)
          if (j != k && pend[j]) wait_cnt[j]++;
        chk("rand.fair", 64'(wait_cnt[k] <= 3), 64'd1);
        wait_cnt[k] = 0;
        pend[k]     = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; en = 1'b1; rdy = 1'b1; v = '0; din = '0;
    b_rst = 1'b1; b_en = 1'b1; b_rdy = 1'b1; b_v = '0; b_din = '0;
    for (int k = 0; k < 4; k++) din[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);

    //            rst en  v     rdy chk r     ev id  data
    tbl[0]  = mk(1, 1, 4'hF, 1, 0, 4'h0, 0, 0, 32'h0);
    tbl[1]  = mk(1, 1, 4'hF, 1, 1, 4'h0, 0, 0, 32'h0);
    tbl[2]  = mk(0, 1, 4'hF, 1, 1, 4'h1, 0, 0, 32'h0);
    tbl[3]  = mk(0, 1, 4'hF, 1, 1, 4'h2, 1, 0, D0);
    tbl[4]  = mk(0, 1, 4'hF, 1, 1, 4'h4, 1, 1, D1);
    tbl[5]  = mk(0, 1, 4'hF, 1, 1, 4'h8, 1, 2, D2);
    tbl[6]  = mk(0, 1, 4'hF, 1, 1, 4'h1, 1, 3, D3);
    tbl[7]  = mk(0, 1, 4'hF, 1, 1, 4'h2, 1, 0, D0);
    tbl[8]  = mk(0, 1, 4'h0, 1, 1, 4'h0, 1, 1, D1);
    tbl[9]  = mk(0, 1, 4'h0, 1, 1, 4'h0, 0, 1, D1);
    tbl[10] = mk(0, 1, 4'h1, 1, 1, 4'h1, 0, 1, D1);
    tbl[11] = mk(0, 1, 4'h8, 1, 1, 4'h8, 1, 0, D0);
    tbl[12] = mk(0, 1, 4'h6, 0, 1, 4'h0, 1, 3, D3);
    tbl[13] = mk(0, 1, 4'h6, 0, 1, 4'h0, 1, 3, D3);
    tbl[14] = mk(0, 0, 4'h6, 1, 1, 4'h0, 0, 3, D3);
    tbl[15] = mk(0, 1, 4'h6, 1, 1, 4'h2, 1, 3, D3);
    tbl[16] = mk(0, 1, 4'h4, 1, 1, 4'h4, 1, 1, D1);
    tbl[17] = mk(0, 1, 4'h0, 0, 1, 4'h0, 1, 2, D2);
    tbl[18] = mk(0, 1, 4'h0, 1, 1, 4'h0, 1, 2, D2);
    tbl[19] = mk(0, 1, 4'h0, 1, 1, 4'h0, 0, 2, D2);
    tbl[20] = mk(0, 1, 4'hF, 1, 1, 4'h8, 0, 2, D2);
    tbl[21] = mk(1, 1, 4'hF, 0, 1, 4'h0, 1, 3, D3);
    tbl[22] = mk(0, 1, 4'hF, 0, 1, 4'h1, 0, 0, 32'h0);

    @(posedge clk); #1;
    for (int i = 0; i < 23; i++) begin
      rst = tbl[i].rst; en = tbl[i].en; v = tbl[i].v; rdy = tbl[i].rdy;
      #2;
      if (tbl[i].chk)
        chk_a($sformatf("tbl%0d", i), tbl[i].exp_r, tbl[i].exp_v, tbl[i].exp_id, tbl[i].exp_d);
      @(posedge clk); #1;
    end

    // Backpressure: held word stays put for 5 cycles, successor loads on the draining edge.
    reset_a();
    din[0 +: 32]  = 32'hA5A5_0001;
    din[32 +: 32] = 32'hA5A5_0002;
    cyc_a("bp.load", 1, 4'h1, 0, 4'h1, 0, 0, 32'h0);
    for (int c = 0; c < 5; c++)
      cyc_a($sformatf("bp.stall%0d", c), 1, 4'h2, 0, 4'h0, 1, 0, 32'hA5A5_0001);
    cyc_a("bp.resume", 1, 4'h2, 1, 4'h2, 1, 0, 32'hA5A5_0001);
    cyc_a("bp.next", 1, 4'h0, 0, 4'h0, 1, 1, 32'hA5A5_0002);

    // Enable freeze mid-stream: word from input 2 is held and re-presented.
    reset_a();
    for (int k = 0; k < 4; k++) din[k*32 +: 32] = 32'hE000_0000 + 32'(k);
    cyc_a("frz.c0", 1, 4'hF, 1, 4'h1, 0, 0, 32'h0);
    cyc_a("frz.c1", 1, 4'hF, 1, 4'h2, 1, 0, 32'hE000_0000);
    cyc_a("frz.c2", 1, 4'hF, 1, 4'h4, 1, 1, 32'hE000_0001);
    for (int c = 0; c < 3; c++)
      cyc_a($sformatf("frz.off%0d", c), 0, 4'hF, 1, 4'h0, 0, 2, 32'hE000_0002);
    cyc_a("frz.c6", 1, 4'hF, 1, 4'h8, 1, 2, 32'hE000_0002);
    cyc_a("frz.c7", 1, 4'hF, 1, 4'h1, 1, 3, 32'hE000_0003);
    cyc_a("frz.c8", 1, 4'h0, 1, 4'h0, 1, 0, 32'hE000_0000);
    cyc_a("frz.c9", 1, 4'h0, 1, 4'h0, 0, 0, 32'hE000_0000);

    // N=3: skip idle input 1 and wrap the pointer 2 -> 0.
    for (int k = 0; k < 3; k++) b_din[k*32 +: 32] = 32'hB000_0000 + 32'(k);
    @(posedge clk); #1;
    b_rst = 1'b0;
    cyc_b("n3.g2", 3'b100, 3'b100, 0, 0, 32'h0);
    cyc_b("n3.g0", 3'b001, 3'b001, 1, 2, 32'hB000_0002);
    cyc_b("n3.skip1", 3'b101, 3'b100, 1, 0, 32'hB000_0000);
    cyc_b("n3.wrap", 3'b001, 3'b001, 1, 2, 32'hB000_0002);
    cyc_b("n3.tail", 3'b000, 3'b000, 1, 0, 32'hB000_0000);

    // Random traffic against a FIFO scoreboard.
    reset_a();
    pend = '0; seq_no = 0;
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int c = 0; c < 400; c++) rand_cycle(1'b1);
    for (int c = 0; c < 100 && (pend != '0 || sb_q.size() != 0); c++) rand_cycle(1'b0);
    chk("rand.drain_q", 64'(sb_q.size()), 64'd0);
    chk("rand.drain_pend", 64'(pend), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
